reorder_sequencer: RTL and testbench

Sequential controller for the 9-lane `reorder_logic` gather datapath, where `data_out_i = data_in[index_i]`. It accepts a 9-sample frame over a valid/ready stream, ranks the samples one per cycle to build the gather index vector, and drives the datapath. It then captures the permuted result and streams it out with backpressure. It sits between the window/sample source and the downstream filter stage, and turns the combinational permuter into a streaming sorter.

---
 rtl/reorder_sequencer.sv | 116 +++++++++++
 tb/tb_reorder_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/reorder_sequencer.sv
// Streaming sorter controller: loads a 9-sample frame, ranks it one sample per
// cycle into a gather index vector, fires the reorder datapath, then streams the result.
module reorder_sequencer #(
  parameter int DATA_W = 8,
  parameter int N      = 9,
  parameter int IDX_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_desc,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic [N*DATA_W-1:0] ro_data_in,
  output logic [N*IDX_W-1:0]  ro_index,
  input  logic [N*DATA_W-1:0] ro_data_out,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic                busy
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {LOAD, RANK, ISSUE, DRAIN} state_t;

  state_t r_state, w_next;

  logic [DATA_W-1:0] r_s   [N];
  logic [IDX_W-1:0]  r_idx [N];
  logic [DATA_W-1:0] r_buf [N];
  logic [IDX_W-1:0]  r_cnt, r_k, r_ocnt;
  logic              r_desc;
  logic [IDX_W-1:0]  w_rank;

  // True when sample a must be placed strictly ahead of sample b (ignoring ties).
  function automatic logic precedes(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b,
                                    input logic desc);
    return desc ? (a > b) : (a < b);
  endfunction

  // Stable rank of sample k: strictly-preceding samples plus equal samples at lower positions.
  always_comb begin
    w_rank = '0;
    for (int j = 0; j < N; j++) begin
      if (precedes(r_s[j], r_s[r_k], r_desc) ||
          ((IDX_W'(j) < r_k) && (r_s[j] == r_s[r_k])))
        w_rank = w_rank + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:    if (in_valid && (r_cnt == LAST)) w_next = RANK;
      RANK:    if (r_k == LAST) w_next = ISSUE;
      ISSUE:   w_next = DRAIN;
      DRAIN:   if (out_ready && (r_ocnt == LAST)) w_next = LOAD;
      default: w_next = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == LOAD);
    busy      = (r_state != LOAD);
    out_valid = (r_state == DRAIN);
    out_last  = (r_state == DRAIN) && (r_ocnt == LAST);
    out_data  = (r_state == DRAIN) ? r_buf[r_ocnt] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_k    <= '0;
      r_ocnt <= '0;
      r_desc <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_s[i]   <= '0;
        r_idx[i] <= IDX_W'(i);
        r_buf[i] <= '0;
      end
    end else begin
      case (r_state)
        LOAD: if (in_valid) begin
          r_s[r_cnt] <= in_data;
          if (r_cnt == '0) r_desc <= cfg_desc;
          r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + IDX_W'(1);
        end
        RANK: begin
          r_idx[w_rank] <= r_k;
          r_k <= (r_k == LAST) ? '0 : r_k + IDX_W'(1);
        end
        ISSUE: begin
          for (int i = 0; i < N; i++) r_buf[i] <= ro_data_out[DATA_W*i +: DATA_W];
        end
        DRAIN: if (out_ready) begin
          r_ocnt <= (r_ocnt == LAST) ? '0 : r_ocnt + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign ro_data_in[DATA_W*g +: DATA_W] = r_s[g];
    assign ro_index[IDX_W*g +: IDX_W]     = r_idx[g];
  end

endmodule

// File: tb/tb_reorder_sequencer.sv
// Directed bench for reorder_sequencer with a behavioural gather datapath model.
module tb_reorder_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_desc = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic [71:0] ro_data_in;
  logic [35:0] ro_index;
  logic [71:0] ro_data_out;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] f_asc [9] = '{8'd2, 8'd6, 8'd8, 8'd10, 8'd18, 8'd20, 8'd22, 8'd24, 8'd26};
  logic [7:0] f_dsc [9] = '{8'd26, 8'd24, 8'd22, 8'd20, 8'd18, 8'd10, 8'd8, 8'd6, 8'd2};
  logic [7:0] f_dup [9] = '{8'd5, 8'd3, 8'd5, 8'd1, 8'd3, 8'd9, 8'd0, 8'd7, 8'd5};
  logic [7:0] o_dup [9] = '{8'd0, 8'd1, 8'd3, 8'd3, 8'd5, 8'd5, 8'd5, 8'd7, 8'd9};
  int i_id  [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
  int i_rev [9] = '{8, 7, 6, 5, 4, 3, 2, 1, 0};
  int i_dup [9] = '{6, 3, 1, 4, 0, 2, 8, 7, 5};

  reorder_sequencer #(.DATA_W(8), .N(9), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .cfg_desc(cfg_desc), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ro_data_in(ro_data_in), .ro_index(ro_index),
    .ro_data_out(ro_data_out), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gather datapath: lane i returns data_in[index_i].
  always_comb begin
    ro_data_out = '0;
    for (int i = 0; i < 9; i++) begin
      int sel;
      sel = int'(ro_index[4*i +: 4]);
      if (sel < 9) ro_data_out[8*i +: 8] = ro_data_in[8*sel +: 8];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] pk_idx(input int e [9]);
    logic [35:0] r;
    for (int i = 0; i < 9; i++) r[4*i +: 4] = 4'(e[i]);
    return r;
  endfunction

  function automatic logic [71:0] pk_dat(input logic [7:0] e [9]);
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[8*i +: 8] = e[i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // cfg_desc flips after the first beat; only the first beat's value may count.
  task automatic push(input logic [7:0] v [9], input logic desc, input int nb);
    for (int i = 0; i < nb; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      cfg_desc = (i == 0) ? desc : ~desc;
      step();
    end
    in_valid = 1'b0;
    cfg_desc = 1'b0;
  endtask

  task automatic wait_valid(input logic chk_lat);
    int n = 0;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
    chk("wait_valid", out_valid, 1'b1);
    if (chk_lat) chk("latency", n, 10);
  endtask

  task automatic drain(input logic [7:0] e [9], input logic bp, input int nb);
    int beat = 0;
    int c = 0;
    logic stalled = 1'b0;
    logic [7:0] prev = '0;
    while (beat < nb && c < 100) begin
      out_ready = bp ? (c % 3 == 0) : 1'b1;
      c++;
      chk("drain_valid", out_valid, 1'b1);
      chk("drain_in_ready", in_ready, 1'b0);
      if (stalled) chk("stall_hold", out_data, prev);
      chk("drain_last", out_last, beat == 8);
      if (out_ready) begin
        chk("drain_data", out_data, e[beat]);
        beat++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        prev = out_data;
      end
      step();
    end
    chk("drain_beats", beat, nb);
    out_ready = 1'b0;
  endtask

  task automatic frame(input logic [7:0] v [9], input logic desc, input int ix [9],
                       input logic [7:0] o [9], input logic bp);
    push(v, desc, 9);
    chk("busy_rank", busy, 1'b1);
    wait_valid(1'b1);
    chk("ro_index", ro_index, pk_idx(ix));
    chk("ro_data_in", ro_data_in, pk_dat(v));
    drain(o, bp, 9);
    chk("post_valid", out_valid, 1'b0);
    chk("post_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    int acc, outs, a0, a9, l0;
    logic seen;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, 8'd0);
    chk("rst_ro_data_in", ro_data_in, 72'd0);
    chk("rst_ro_index", ro_index, pk_idx(i_id));

    frame(f_asc, 1'b0, i_id, f_asc, 1'b0);
    frame(f_asc, 1'b1, i_rev, f_dsc, 1'b0);
    frame(f_dup, 1'b0, i_dup, o_dup, 1'b0);
    frame(f_asc, 1'b0, i_id, f_asc, 1'b1);

    // Reset partway through loading.
    push(f_dup, 1'b1, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midload_in_ready", in_ready, 1'b1);
    chk("midload_busy", busy, 1'b0);
    chk("midload_ro_data_in", ro_data_in, 72'd0);
    frame(f_dup, 1'b0, i_dup, o_dup, 1'b0);

    // Reset partway through draining.
    push(f_asc, 1'b0, 9);
    wait_valid(1'b0);
    drain(f_asc, 1'b0, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("middrain_valid", out_valid, 1'b0);
    seen = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      seen = seen | out_valid;
      step();
    end
    out_ready = 1'b0;
    chk("middrain_no_stale", seen, 1'b0);

    // Back-to-back frames with in_valid and out_ready held high.
    acc = 0; outs = 0; a0 = -1; a9 = -1; l0 = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 150 && outs < 18; c++) begin
      if (acc < 18) begin
        in_valid = 1'b1;
        if (in_ready) begin
          in_data  = (acc < 9) ? f_asc[acc] : f_asc[acc-9];
          cfg_desc = (acc >= 9);
          if (acc == 0) a0 = cyc + 1;
          if (acc == 9) a9 = cyc + 1;
          acc++;
        end
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        chk("b2b_data", out_data, (outs < 9) ? f_asc[outs] : f_dsc[outs-9]);
        if (outs == 8) begin
          chk("b2b_last", out_last, 1'b1);
          l0 = cyc + 1;
        end
        outs++;
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_beats", outs, 18);
    chk("b2b_period", a9 - a0, 28);
    chk("b2b_after_last", a9 - l0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
